// File: rtl/simon_io_pkg.sv
// rtl/simon_io_pkg.sv - shared address map, colour codes, player states and CTRL bit indices
package simon_io_pkg;

    localparam logic [11:0] ADDR_LED    = 12'd6;
    localparam logic [11:0] ADDR_AUDIO  = 12'd8;
    localparam logic [11:0] ADDR_PUSH   = 12'd11;
    localparam logic [11:0] ADDR_CTRL   = 12'd12;
    localparam logic [11:0] ADDR_STATUS = 12'd13;

    localparam logic [1:0] COL_RED    = 2'd0;
    localparam logic [1:0] COL_BLUE   = 2'd1;
    localparam logic [1:0] COL_GREEN  = 2'd2;
    localparam logic [1:0] COL_YELLOW = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } player_state_t;

endpackage

// File: rtl/pattern_mem.sv
// rtl/pattern_mem.sv - DEPTH x 2 colour pattern store, synchronous write, asynchronous read
// Ports:
//   clock, reset : system clock, asynchronous active-high reset (clears all entries)
//   we           : write enable
//   waddr, wdata : write address and colour
//   raddr, rdata : combinational read port
module pattern_mem #(
    parameter int DEPTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [1:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [1:0]               rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'd0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_pattern_player.sv
// rtl/simon_pattern_player.sv - memory-mapped colour pattern sequencer owning the LED and audio peripherals
// Optional feature macro: PLAYER_SPEEDUP_EN (ON hold shrinks as the pattern grows).
// Ports:
//   clock, reset           : system clock, asynchronous active-high reset
//   wEn, addr, dataIn      : CPU store bus
//   dataOut                : status word when addr is ADDR_STATUS, else 0
//   led_strobe/color/on    : registered LED command
//   audio_strobe/color/on  : registered audio command
//   busy                   : player in ON or GAP
//   done_pulse             : one cycle at end of playback
module simon_pattern_player
    import simon_io_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000,
    parameter int CNT_W      = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wEn,
    input  logic [11:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        led_strobe,
    output logic [1:0]  led_color,
    output logic        led_on,
    output logic        audio_strobe,
    output logic [2:0]  audio_color,
    output logic        audio_on,
    output logic        busy,
    output logic        done_pulse
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [5:0] DEPTH_L = 6'(DEPTH);

    player_state_t    state_q, state_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] on_hold_q, on_hold_d;

    logic             led_strobe_q, led_strobe_d;
    logic [1:0]       led_color_q, led_color_d;
    logic             led_on_q, led_on_d;
    logic             audio_strobe_q, audio_strobe_d;
    logic [2:0]       audio_color_q, audio_color_d;
    logic             audio_on_q, audio_on_d;
    logic             done_q, done_d;

    logic             mem_we;
    logic [AW-1:0]    rd_addr;
    logic [1:0]       rd_col;

    logic             push_wr, led_wr, audio_wr, ctrl_wr, do_clear, do_start;
    logic [CNT_W-1:0] hold_raw, start_hold;
    logic             unused_data;

    assign unused_data = ^dataIn[31:4];

    assign push_wr  = wEn && (addr == ADDR_PUSH);
    assign led_wr   = wEn && (addr == ADDR_LED);
    assign audio_wr = wEn && (addr == ADDR_AUDIO);
    assign ctrl_wr  = wEn && (addr == ADDR_CTRL);
    assign do_clear = ctrl_wr && dataIn[CTRL_CLEAR];
    assign do_start = ctrl_wr && dataIn[CTRL_START] && !dataIn[CTRL_CLEAR];

`ifdef PLAYER_SPEEDUP_EN
    logic [1:0] speed_sh;
    // len/8 saturated at 3; below 24 entries bit 5 is clear so bits [4:3] are len/8
    assign speed_sh = (len_q >= 6'd24) ? 2'd3 : len_q[4:3];
    assign hold_raw = CNT_W'(ON_CYCLES) >> speed_sh;
`else
    assign hold_raw = CNT_W'(ON_CYCLES);
`endif
    // a hold of zero would underflow the counter load, so it is floored at one clock
    assign start_hold = (hold_raw == '0) ? CNT_W'(1) : hold_raw;

    // In GAP the next ON entry's colour must be ready on the cycle the on-strobe is registered
    assign rd_addr = (state_q == GAP) ? (idx_q[AW-1:0] + AW'(1)) : idx_q[AW-1:0];

    pattern_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clock(clock),
        .reset(reset),
        .we   (mem_we),
        .waddr(len_q[AW-1:0]),
        .wdata(dataIn[1:0]),
        .raddr(rd_addr),
        .rdata(rd_col)
    );

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        ovf_d          = ovf_q;
        cnt_d          = cnt_q;
        on_hold_d      = on_hold_q;
        led_strobe_d   = 1'b0;
        led_color_d    = led_color_q;
        led_on_d       = led_on_q;
        audio_strobe_d = 1'b0;
        audio_color_d  = audio_color_q;
        audio_on_d     = audio_on_q;
        done_d         = 1'b0;
        mem_we         = 1'b0;

        if (state_q == IDLE) begin
            if (push_wr) begin
                if (len_q == DEPTH_L) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    len_d  = len_q + 6'd1;
                end
            end
            if (led_wr) begin
                led_strobe_d = 1'b1;
                led_color_d  = dataIn[2:1];
                led_on_d     = dataIn[0];
            end
            if (audio_wr) begin
                audio_strobe_d = 1'b1;
                audio_color_d  = dataIn[3:1];
                audio_on_d     = dataIn[0];
            end
            if (do_clear) begin
                len_d = 6'd0;
                ovf_d = 1'b0;
            end else if (do_start) begin
                if (len_q == 6'd0) begin
                    done_d = 1'b1;
                end else begin
                    state_d        = ON;
                    idx_d          = 6'd0;
                    on_hold_d      = start_hold;
                    cnt_d          = start_hold - CNT_W'(1);
                    led_strobe_d   = 1'b1;
                    led_color_d    = rd_col;
                    led_on_d       = 1'b1;
                    audio_strobe_d = 1'b1;
                    audio_color_d  = {1'b0, rd_col};
                    audio_on_d     = 1'b1;
                end
            end
        end else begin
            if (push_wr) begin
                ovf_d = 1'b1;
            end
            if (do_clear) begin
                // abort: silence both peripherals and forget the pattern length
                state_d        = IDLE;
                len_d          = 6'd0;
                idx_d          = 6'd0;
                ovf_d          = 1'b0;
                led_strobe_d   = 1'b1;
                led_on_d       = 1'b0;
                audio_strobe_d = 1'b1;
                audio_on_d     = 1'b0;
            end else if (state_q == ON) begin
                if (cnt_q == '0) begin
                    state_d        = GAP;
                    cnt_d          = CNT_W'(GAP_CYCLES - 1);
                    led_strobe_d   = 1'b1;
                    led_on_d       = 1'b0;
                    audio_strobe_d = 1'b1;
                    audio_on_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    if (idx_q == len_q - 6'd1) begin
                        state_d = IDLE;
                        idx_d   = 6'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d        = ON;
                        idx_d          = idx_q + 6'd1;
                        cnt_d          = on_hold_q - CNT_W'(1);
                        led_strobe_d   = 1'b1;
                        led_color_d    = rd_col;
                        led_on_d       = 1'b1;
                        audio_strobe_d = 1'b1;
                        audio_color_d  = {1'b0, rd_col};
                        audio_on_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= 6'd0;
            idx_q          <= 6'd0;
            ovf_q          <= 1'b0;
            cnt_q          <= '0;
            on_hold_q      <= '0;
            led_strobe_q   <= 1'b0;
            led_color_q    <= 2'd0;
            led_on_q       <= 1'b0;
            audio_strobe_q <= 1'b0;
            audio_color_q  <= 3'd0;
            audio_on_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            ovf_q          <= ovf_d;
            cnt_q          <= cnt_d;
            on_hold_q      <= on_hold_d;
            led_strobe_q   <= led_strobe_d;
            led_color_q    <= led_color_d;
            led_on_q       <= led_on_d;
            audio_strobe_q <= audio_strobe_d;
            audio_color_q  <= audio_color_d;
            audio_on_q     <= audio_on_d;
            done_q         <= done_d;
        end
    end

    assign led_strobe   = led_strobe_q;
    assign led_color    = led_color_q;
    assign led_on       = led_on_q;
    assign audio_strobe = audio_strobe_q;
    assign audio_color  = audio_color_q;
    assign audio_on     = audio_on_q;
    assign done_pulse   = done_q;
    assign busy         = (state_q != IDLE);

    assign dataOut = (addr == ADDR_STATUS)
                   ? {18'd0, ovf_q, busy, idx_q, len_q}
                   : 32'd0;

endmodule
